// File: rtl/fsk_frame_demod.sv
// FSK receive demodulator: hysteresis slicer, zero-crossing interval timer,
// short-pair / long-half symbol decoder and frame assembler with valid/ack handshake.
module fsk_frame_demod #(
  parameter int SAMPLE_W   = 8,
  parameter int MIDPOINT   = 128,
  parameter int HYST       = 4,
  parameter int SHORT_MAX  = 24,
  parameter int TIMEOUT    = 96,
  parameter int FRAME_BITS = 16,
  parameter int CNT_W      = 8
) (
  input  logic                              G_CLK_RX,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [SAMPLE_W-1:0]               in_signal,
  input  logic                              data_ack,
  output logic [FRAME_BITS-1:0]             data,
  output logic                              data_valid,
  output logic                              overrun,
  output logic                              sym_err,
  output logic                              status,
  output logic [$clog2(FRAME_BITS+1)-1:0]   bit_count
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);
  // Thresholds carry one extra bit so MIDPOINT +/- HYST cannot wrap.
  localparam logic [SAMPLE_W:0]   HI_TH     = (SAMPLE_W+1)'(MIDPOINT + HYST);
  localparam logic [SAMPLE_W:0]   LO_TH     = (SAMPLE_W+1)'(MIDPOINT - HYST);
  localparam logic [CNT_W-1:0]    TO_CNT    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]    TO_PRE    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    SHORT_CNT = CNT_W'(SHORT_MAX);
  localparam logic [BC_W-1:0]     LAST_BIT  = BC_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_HALF} state_t;

  state_t                state_q, state_d;
  logic                  s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  dv_q, dv_d;
  logic                  ov_q, ov_d;
  logic                  sym_err_q, sym_err_d;
  logic                  status_q, status_d;

  logic [SAMPLE_W:0]     in_ext;
  logic                  edge_w;
  logic                  is_short;
  logic                  timed_out;
  logic                  bit_vld;
  logic                  bit_val;
  logic                  frame_done;
  logic [FRAME_BITS-1:0] frame_w;

  assign in_ext    = {1'b0, in_signal};
  assign edge_w    = s1_q ^ s2_q;
  // P = cnt+1, so P <= SHORT_MAX is cnt < SHORT_MAX and P >= TIMEOUT is cnt >= TIMEOUT-1.
  assign is_short  = (cnt_q < SHORT_CNT);
  assign timed_out = (cnt_q >= TO_PRE);

  always_comb begin
    s1_d = s1_q;
    if (in_ext > HI_TH)      s1_d = 1'b1;
    else if (in_ext < LO_TH) s1_d = 1'b0;
    s2_d = s1_q;

    if (!enable || edge_w)   cnt_d = '0;
    else if (cnt_q == TO_CNT) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + CNT_W'(1);

    state_d   = state_q;
    shift_d   = shift_q;
    bc_d      = bc_q;
    bit_vld   = 1'b0;
    bit_val   = 1'b0;
    sym_err_d = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      shift_d = '0;
      bc_d    = '0;
    end else if (state_q == ST_IDLE) begin
      if (edge_w) state_d = ST_HUNT;
    end else if (timed_out) begin
      // Carrier loss wins over any edge arriving on the same clock.
      state_d = ST_IDLE;
      shift_d = '0;
      bc_d    = '0;
    end else if (edge_w) begin
      case (state_q)
        ST_HUNT: begin
          if (is_short) state_d = ST_HALF;
          else          bit_vld = 1'b1;
        end
        ST_HALF: begin
          state_d = ST_HUNT;
          if (is_short) begin
            bit_vld = 1'b1;
            bit_val = 1'b1;
          end else begin
            sym_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    frame_w    = {shift_q, bit_val};
    frame_done = bit_vld && (bc_q == LAST_BIT);
    if (bit_vld) begin
      shift_d = frame_w[FRAME_BITS-2:0];
      bc_d    = frame_done ? '0 : bc_q + BC_W'(1);
    end

    data_d = data_q;
    dv_d   = dv_q;
    ov_d   = ov_q;
    if (data_ack) begin
      dv_d = 1'b0;
      ov_d = 1'b0;
    end
    if (frame_done) begin
      if (!dv_q || data_ack) begin
        data_d = frame_w;
        dv_d   = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end

    status_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge G_CLK_RX or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      bc_q      <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      ov_q      <= 1'b0;
      sym_err_q <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bc_q      <= bc_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ov_q      <= ov_d;
      sym_err_q <= sym_err_d;
      status_q  <= status_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign overrun    = ov_q;
  assign sym_err    = sym_err_q;
  assign status     = status_q;
  assign bit_count  = bc_q;

endmodule
